oled_refresh_ctrl: RTL and testbench
====================================

OLED_REFRESH_CTRL -- requirements
Module: oled_refresh_ctrl

Interface
REQ-001 SHALL provide parameter STARTUP_WAIT, default 10000000: cycles per power-up phase (reset low, then settle).
REQ-002 SHALL provide parameter SCLK_HALF, default 2: clk cycles per SCLK half-period (>=1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high: refresh frames back-to-back; sampled only at frame boundaries.
REQ-006 SHALL have port pixel_data  input  8  display byte from text engine, registered, valid 1 cycle after pixel_address.
REQ-007 SHALL have port pixel_address  output  10  byte index to text engine: [9:7] page, [6:0] column.
REQ-008 SHALL have ports oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n  output  1 each  SSD1306 4-wire SPI and reset pins.
REQ-009 SHALL have ports init_done  output  1  (sticky after init ROM sent), frame_done  output  1  (1-cycle pulse), busy  output  1  (high in every state except IDLE).

Function
REQ-010 States: PWR_RESET, PWR_WAIT, INIT_LOAD, DATA_ADDR, DATA_WAIT, DATA_LOAD, SHIFT, NEXT, IDLE.
REQ-011 PWR_RESET: oled_res_n=0 for STARTUP_WAIT cycles -> PWR_WAIT: oled_res_n=1 for STARTUP_WAIT cycles -> INIT_LOAD.
REQ-012 Init ROM, 18 bytes, sent in order with oled_dc=0: AE 8D 14 20 00 A1 C8 81 7F A4 A6 21 00 7F 22 00 07 AF.
REQ-013 INIT_LOAD: load ROM[i] into shift register, oled_cs_n<=0 -> SHIFT; init sequence runs regardless of enable.
REQ-014 SHIFT: MSB first; per bit, oled_sdin=bit with oled_sclk=0 for SCLK_HALF cycles, then oled_sclk=1 for SCLK_HALF cycles (SPI mode 0); byte = 16*SCLK_HALF cycles.
REQ-015 After 8th bit's high phase: oled_sclk<=0, oled_cs_n<=1 -> NEXT; oled_cs_n high >=1 cycle between bytes.
REQ-016 NEXT during init: i<17 -> i+1, INIT_LOAD; i=17 -> init_done<=1, pixel_address<=0, then DATA_ADDR if enable else IDLE.
REQ-017 DATA_ADDR: hold pixel_address -> DATA_WAIT (1 cycle) -> DATA_LOAD: capture pixel_data into shift register, oled_dc<=1, oled_cs_n<=0 -> SHIFT.
REQ-018 NEXT during data: pixel_address<1023 -> increment, DATA_ADDR; =1023 -> frame_done pulse 1 cycle, pixel_address wraps to 0, DATA_ADDR if enable else IDLE.
REQ-019 enable falling mid-frame SHALL NOT abort; frame completes all 1024 bytes.
REQ-020 IDLE: oled_cs_n=1, oled_sclk=0, busy=0; enable high -> DATA_ADDR next cycle at pixel_address 0; no re-init.
REQ-021 pixel_address SHALL be stable from DATA_ADDR through DATA_LOAD; changes only in NEXT.
REQ-022 Counters: startup counter wide enough for STARTUP_WAIT; bit counter 3 bits; ROM index 5 bits; address 10 bits wraps 1023->0.

Reset
REQ-023 rst_n low SHALL immediately force: state PWR_RESET, oled_res_n=0, oled_cs_n=1, oled_sclk=0, oled_sdin=0, oled_dc=0, pixel_address=0, init_done=0, frame_done=0, counters 0; busy=1.
REQ-024 Reset asserted mid-byte or mid-frame SHALL abandon transfer; after release full power-up and init repeat from start.

Verification (STARTUP_WAIT=4, SCLK_HALF=1)
REQ-025 Release reset -> oled_res_n low 4 cycles, high 4 cycles, then first SPI byte 0xAE, dc=0, 16 cycles with cs_n low.
REQ-026 Decode SPI with enable=0 -> exactly 18 init bytes matching REQ-012, init_done=1, IDLE, cs_n=1, busy=0.
REQ-027 enable=1, model text engine returning pixel_data=pixel_address[7:0] one cycle late -> 1024 bytes, dc=1, values 00..FF repeating in address order, one frame_done pulse after byte 1023.
REQ-028 Drop enable at byte 500 -> bytes 500..1023 still sent, frame_done pulses, then IDLE; raise enable -> next byte from address 0.
REQ-029 Assert rst_n low mid-bit of data byte -> same cycle cs_n=1, sclk=0, res_n=0, init_done=0; after release init replays from 0xAE.
REQ-030 Continuous enable -> frame_done pulses spaced exactly 1024*(16+4) cycles; pixel_address wraps 1023->0.

Source files
------------

// File: rtl/oled_refresh_ctrl.sv
// SSD1306 refresh controller: power-up sequencing, init ROM playback, then
// continuous 1024-byte framebuffer streaming over 4-wire SPI (mode 0).
//
// state     | meaning
// PWR_RESET | hold oled_res_n low for STARTUP_WAIT cycles
// PWR_WAIT  | oled_res_n high, let the panel settle for STARTUP_WAIT cycles
// INIT_LOAD | load next init ROM byte (dc=0), open chip select
// DATA_ADDR | pixel_address presented to the text engine
// DATA_WAIT | text engine registers its answer
// DATA_LOAD | capture pixel_data (dc=1), open chip select
// SHIFT     | clock eight bits out MSB first
// NEXT      | chip select high, advance ROM index or pixel address
// IDLE      | framebuffer streaming paused, waiting for enable
module oled_refresh_ctrl #(
    parameter int STARTUP_WAIT = 10000000,
    parameter int SCLK_HALF    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] pixel_data,
    output logic [9:0] pixel_address,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_cs_n,
    output logic       oled_dc,
    output logic       oled_res_n,
    output logic       init_done,
    output logic       frame_done,
    output logic       busy
);

    localparam int SW_W   = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [SW_W-1:0]   STARTUP_LAST = SW_W'(STARTUP_WAIT - 1);
    localparam logic [HALF_W-1:0] HALF_LAST    = HALF_W'(SCLK_HALF - 1);
    localparam logic [4:0]        ROM_LAST     = 5'd17;
    localparam logic [9:0]        ADDR_LAST    = 10'd1023;

    typedef enum logic [3:0] {
        PWR_RESET,
        PWR_WAIT,
        INIT_LOAD,
        DATA_ADDR,
        DATA_WAIT,
        DATA_LOAD,
        SHIFT,
        NEXT,
        IDLE
    } state_t;

    state_t state, state_next;

    logic [SW_W-1:0]   startup_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic [2:0]        bit_cnt;
    logic [4:0]        rom_idx;
    logic [6:0]        shreg;   // bits still to send after the one on oled_sdin

    logic startup_end;
    logic half_end;
    logic byte_end;
    logic [7:0] rom_byte;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'h8D;
            5'd2:    b = 8'h14;
            5'd3:    b = 8'h20;
            5'd4:    b = 8'h00;
            5'd5:    b = 8'hA1;
            5'd6:    b = 8'hC8;
            5'd7:    b = 8'h81;
            5'd8:    b = 8'h7F;
            5'd9:    b = 8'hA4;
            5'd10:   b = 8'hA6;
            5'd11:   b = 8'h21;
            5'd12:   b = 8'h00;
            5'd13:   b = 8'h7F;
            5'd14:   b = 8'h22;
            5'd15:   b = 8'h00;
            5'd16:   b = 8'h07;
            5'd17:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign rom_byte    = init_rom(rom_idx);
    assign startup_end = (startup_cnt == STARTUP_LAST);
    assign half_end    = (half_cnt == HALF_LAST);
    assign byte_end    = half_end && oled_sclk && (bit_cnt == 3'd7);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PWR_RESET: if (startup_end) state_next = PWR_WAIT;
            PWR_WAIT:  if (startup_end) state_next = INIT_LOAD;
            INIT_LOAD: state_next = SHIFT;
            DATA_ADDR: state_next = DATA_WAIT;
            DATA_WAIT: state_next = DATA_LOAD;
            DATA_LOAD: state_next = SHIFT;
            SHIFT:     if (byte_end) state_next = NEXT;
            NEXT: begin
                if (!init_done) begin
                    if (rom_idx == ROM_LAST) begin
                        state_next = enable ? DATA_ADDR : IDLE;
                    end else begin
                        state_next = INIT_LOAD;
                    end
                end else if (pixel_address == ADDR_LAST) begin
                    // enable only matters at frame boundaries
                    state_next = enable ? DATA_ADDR : IDLE;
                end else begin
                    state_next = DATA_ADDR;
                end
            end
            IDLE:      if (enable) state_next = DATA_ADDR;
            default:   state_next = PWR_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startup_cnt   <= '0;
            half_cnt      <= '0;
            bit_cnt       <= '0;
            rom_idx       <= '0;
            shreg         <= '0;
            pixel_address <= '0;
            oled_res_n    <= 1'b0;
            oled_cs_n     <= 1'b1;
            oled_sclk     <= 1'b0;
            oled_sdin     <= 1'b0;
            oled_dc       <= 1'b0;
            init_done     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                PWR_RESET: begin
                    if (startup_end) begin
                        startup_cnt <= '0;
                        oled_res_n  <= 1'b1;
                    end else begin
                        startup_cnt <= startup_cnt + 1'b1;
                    end
                end
                PWR_WAIT: begin
                    if (startup_end) begin
                        startup_cnt <= '0;
                    end else begin
                        startup_cnt <= startup_cnt + 1'b1;
                    end
                end
                INIT_LOAD: begin
                    shreg     <= rom_byte[6:0];
                    oled_sdin <= rom_byte[7];
                    oled_dc   <= 1'b0;
                    oled_cs_n <= 1'b0;
                    oled_sclk <= 1'b0;
                    half_cnt  <= '0;
                    bit_cnt   <= '0;
                end
                DATA_LOAD: begin
                    shreg     <= pixel_data[6:0];
                    oled_sdin <= pixel_data[7];
                    oled_dc   <= 1'b1;
                    oled_cs_n <= 1'b0;
                    oled_sclk <= 1'b0;
                    half_cnt  <= '0;
                    bit_cnt   <= '0;
                end
                SHIFT: begin
                    if (half_end) begin
                        half_cnt <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else begin
                            oled_sclk <= 1'b0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                oled_cs_n <= 1'b1;
                            end else begin
                                oled_sdin <= shreg[6];
                                shreg     <= {shreg[5:0], 1'b0};
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (!init_done) begin
                        if (rom_idx == ROM_LAST) begin
                            init_done     <= 1'b1;
                            pixel_address <= '0;
                        end else begin
                            rom_idx <= rom_idx + 1'b1;
                        end
                    end else if (pixel_address == ADDR_LAST) begin
                        frame_done    <= 1'b1;
                        pixel_address <= '0;
                    end else begin
                        pixel_address <= pixel_address + 1'b1;
                    end
                end
                IDLE: begin
                    oled_cs_n <= 1'b1;
                    oled_sclk <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_refresh_ctrl.sv
// Bench for oled_refresh_ctrl: SPI decoder plus a byte-stream reference model
// built from the init ROM list and the text engine contents.
module tb_oled_refresh_ctrl;

    localparam int SW = 4;
    localparam int SH = 1;
    localparam int BYTE_CYC = 16 * SH + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pixel_data = 8'h00;
    logic [9:0] pixel_address;
    logic       oled_sclk, oled_sdin, oled_cs_n, oled_dc, oled_res_n;
    logic       init_done, frame_done, busy;

    oled_refresh_ctrl #(.STARTUP_WAIT(SW), .SCLK_HALF(SH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_data(pixel_data),
        .pixel_address(pixel_address), .oled_sclk(oled_sclk), .oled_sdin(oled_sdin),
        .oled_cs_n(oled_cs_n), .oled_dc(oled_dc), .oled_res_n(oled_res_n),
        .init_done(init_done), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // text engine: registered answer, one cycle after the address
    logic       mode_rand = 1'b0;
    logic [7:0] mem [1024];
    always @(posedge clk) pixel_data <= mode_rand ? mem[pixel_address] : pixel_address[7:0];

    logic [7:0] rom [18] = '{8'hAE, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'h81, 8'h7F,
                             8'hA4, 8'hA6, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hAF};

    // SPI decoder, sampled on the falling clock edge
    logic [7:0] rx_sh = 8'h00;
    int         rx_bits = 0;
    int         cs_low = 0;
    logic       prev_sclk = 1'b0;
    logic [7:0] rx_q[$];
    logic       rx_dc_q[$];
    int         cs_run_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_bits = 0;
            cs_low = 0;
            prev_sclk = 1'b0;
        end else begin
            if (oled_sclk && !prev_sclk && !oled_cs_n) begin
                rx_sh = {rx_sh[6:0], oled_sdin};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_q.push_back(rx_sh);
                    rx_dc_q.push_back(oled_dc);
                    rx_bits = 0;
                end
            end
            if (!oled_cs_n) begin
                cs_low++;
            end else if (cs_low != 0) begin
                cs_run_q.push_back(cs_low);
                cs_low = 0;
            end
            prev_sclk = oled_sclk;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_dc_q.delete();
        cs_run_q.delete();
    endtask

    initial begin
        int n;
        int lows;
        int highs;
        int mism;
        int fd1;
        int fd2;

        foreach (mem[i]) mem[i] = 8'($urandom);

        // reset values
        repeat (3) tick();
        check("rst_res_n", 32'(oled_res_n), 32'd0);
        check("rst_cs_n", 32'(oled_cs_n), 32'd1);
        check("rst_sclk", 32'(oled_sclk), 32'd0);
        check("rst_sdin", 32'(oled_sdin), 32'd0);
        check("rst_dc", 32'(oled_dc), 32'd0);
        check("rst_addr", 32'(pixel_address), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // power-up phases
        rst_n = 1'b1;
        lows = 0;
        while (!oled_res_n && lows < 100) begin lows++; tick(); end
        check("res_n_low_cycles", 32'(lows), 32'(SW));
        highs = 0;
        while (oled_cs_n && highs < 100) begin highs++; tick(); end
        check("res_n_high_before_spi", 32'(highs), 32'(SW + 1));
        n = 0;
        while (cs_run_q.size() < 1 && n < 200) begin n++; tick(); end
        check("first_byte_seen", 32'(rx_q.size() >= 1), 32'd1);
        if (rx_q.size() >= 1) begin
            check("first_byte_val", 32'(rx_q[0]), 32'hAE);
            check("first_byte_dc", 32'(rx_dc_q[0]), 32'd0);
        end
        if (cs_run_q.size() >= 1) check("first_byte_cs_len", 32'(cs_run_q[0]), 32'(16 * SH));

        // init sequence with enable low
        n = 0;
        while (!init_done && n < 2000) begin n++; tick(); end
        check("init_done_seen", 32'(init_done), 32'd1);
        repeat (3) tick();
        check("init_byte_count", 32'(rx_q.size()), 32'd18);
        mism = 0;
        for (int k = 0; k < 18; k++)
            if (rx_q[k] !== rom[k] || rx_dc_q[k] !== 1'b0) mism++;
        check("init_bytes_match", 32'(mism), 32'd0);
        mism = 0;
        foreach (cs_run_q[k]) if (cs_run_q[k] != 16 * SH) mism++;
        check("init_cs_runs", 32'(mism), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cs_n", 32'(oled_cs_n), 32'd1);
        check("idle_sclk", 32'(oled_sclk), 32'd0);

        // frame 1: pixel_data = address low byte
        clear_rx();
        enable = 1'b1;
        n = 0;
        while (!frame_done && n < 25000) begin n++; tick(); end
        check("frame1_done_seen", 32'(frame_done), 32'd1);
        mode_rand = 1'b1;
        fd1 = cyc;
        check("frame1_addr_wrap", 32'(pixel_address), 32'd0);
        check("frame1_byte_count", 32'(rx_q.size()), 32'd1024);
        mism = 0;
        for (int k = 0; k < 1024; k++)
            if (rx_q[k] !== 8'(k) || rx_dc_q[k] !== 1'b1) mism++;
        check("frame1_bytes_match", 32'(mism), 32'd0);
        clear_rx();
        tick();
        check("frame_done_pulse_width", 32'(frame_done), 32'd0);

        // frame 2: random contents, enable dropped at byte 500
        n = 0;
        while (rx_q.size() < 500 && n < 25000) begin n++; tick(); end
        enable = 1'b0;
        n = 0;
        while (!frame_done && n < 25000) begin n++; tick(); end
        check("frame2_done_seen", 32'(frame_done), 32'd1);
        fd2 = cyc;
        check("frame_spacing", 32'(fd2 - fd1), 32'(1024 * BYTE_CYC));
        check("frame2_byte_count", 32'(rx_q.size()), 32'd1024);
        mism = 0;
        for (int k = 0; k < 1024; k++)
            if (rx_q[k] !== mem[k] || rx_dc_q[k] !== 1'b1) mism++;
        check("frame2_bytes_match", 32'(mism), 32'd0);
        repeat (10) tick();
        check("post_frame_busy", 32'(busy), 32'd0);
        check("post_frame_cs_n", 32'(oled_cs_n), 32'd1);
        check("post_frame_addr", 32'(pixel_address), 32'd0);
        check("post_frame_no_bytes", 32'(rx_q.size()), 32'd1024);

        // restart from IDLE
        clear_rx();
        enable = 1'b1;
        n = 0;
        while (rx_q.size() < 2 && n < 500) begin n++; tick(); end
        check("restart_byte0", 32'(rx_q[0]), 32'(mem[0]));
        check("restart_byte1", 32'(rx_q[1]), 32'(mem[1]));

        // reset mid-bit
        n = 0;
        while (!(oled_sclk && !oled_cs_n) && n < 100) begin n++; tick(); end
        check("midbit_reached", 32'(oled_sclk && !oled_cs_n), 32'd1);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("abort_cs_n", 32'(oled_cs_n), 32'd1);
        check("abort_sclk", 32'(oled_sclk), 32'd0);
        check("abort_res_n", 32'(oled_res_n), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        clear_rx();
        rst_n = 1'b1;
        n = 0;
        while (!init_done && n < 2000) begin n++; tick(); end
        check("reinit_done_seen", 32'(init_done), 32'd1);
        repeat (3) tick();
        check("reinit_byte_count", 32'(rx_q.size()), 32'd18);
        mism = 0;
        for (int k = 0; k < 18; k++)
            if (rx_q[k] !== rom[k] || rx_dc_q[k] !== 1'b0) mism++;
        check("reinit_bytes_match", 32'(mism), 32'd0);
        check("reinit_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
